// File: rtl/rvfi_check_seq_pkg.sv
// Shared types and helpers for the RVFI check sequencer.
package rvfi_check_seq_pkg;

  localparam int ORDER_W  = 64;
  localparam int RC_W     = 16;
  localparam int MAX_NRET = 32;
  localparam int POP_W    = 6;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Narrower retire buses are zero-extended to MAX_NRET by the caller.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_NRET-1:0] bits);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_NRET; i++) begin
      n = n + {{(POP_W-1){1'b0}}, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rvfi_check_sequencer_counter.sv
// Saturating count of retired instructions across all RVFI channels.
module rvfi_retire_counter
  import rvfi_check_seq_pkg::*;
#(
  parameter int NRET = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [NRET-1:0] valid,
  output logic [RC_W-1:0] count
);

  logic [MAX_NRET-1:0] valid_ext_s;
  logic [POP_W-1:0]    pop_s;
  logic [RC_W:0]       sum_s;

  assign valid_ext_s = MAX_NRET'(valid);
  assign pop_s       = popcount(valid_ext_s);
  assign sum_s       = {1'b0, count} + (RC_W+1)'(pop_s);

  // Accumulate while enabled; the carry-out bit clamps the count at all-ones.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= sum_s[RC_W] ? '1 : sum_s[RC_W-1:0];
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Schedules the single check strobe for one RVFI checker: reset hold window,
// then a depth-bounded run window that fires on retirement of target_order.
module rvfi_check_sequencer
  import rvfi_check_seq_pkg::*;
#(
  parameter int NRET      = 1,
  parameter int CHANNEL   = 0,
  parameter int RST_CYC   = 1,
  parameter int DEPTH_MIN = 10,
  parameter int DEPTH_MAX = 20,
  parameter int SKIP      = 0,
  localparam int CW       = $clog2(DEPTH_MAX + 2)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [ORDER_W*NRET-1:0] rvfi_order,
  input  logic [ORDER_W-1:0]      target_order,
  output logic                    core_reset,
  output logic                    armed,
  output logic                    check,
  output logic                    done,
  output logic                    timeout,
  output logic [RC_W-1:0]         retire_count,
  output logic [CW-1:0]           cycle_count
);

  localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  seq_state_e          state_r;
  seq_state_e          next_state_s;
  logic [HW-1:0]       hold_cnt_r;
  logic [CW-1:0]       cycle_cnt_r;
  logic                timeout_r;
  logic                timeout_s;
  logic                window_s;
  logic                skip_ok_s;
  logic [ORDER_W-1:0]  sel_order_s;

  rvfi_retire_counter #(
    .NRET (NRET)
  ) u_retire_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_r == HOLD),
    .enable (state_r == RUN),
    .valid  (rvfi_valid),
    .count  (retire_count)
  );

  // SKIP of zero is trivially met; avoids an always-true unsigned compare.
  if (SKIP == 0) begin : g_no_skip
    assign skip_ok_s = 1'b1;
  end else begin : g_skip
    assign skip_ok_s = (retire_count >= RC_W'(SKIP));
  end

  assign window_s    = (cycle_count >= CW'(DEPTH_MIN)) && (cycle_count <= CW'(DEPTH_MAX));
  assign sel_order_s = rvfi_order[ORDER_W*CHANNEL +: ORDER_W];
  assign armed       = (state_r == RUN) && window_s && skip_ok_s;
  assign check       = armed && rvfi_valid[CHANNEL] && (sel_order_s == target_order);
  assign core_reset  = (state_r == HOLD);
  assign done        = (state_r == DONE);
  assign timeout     = timeout_r;
  assign cycle_count = cycle_cnt_r;

  // Next-state logic; a fire on the last window cycle takes priority over timeout.
  always_comb begin
    next_state_s = state_r;
    timeout_s    = 1'b0;
    case (state_r)
      HOLD: begin
        if (hold_cnt_r == HW'(RST_CYC - 1)) begin
          next_state_s = RUN;
        end else begin
          next_state_s = HOLD;
        end
      end
      RUN: begin
        if (check) begin
          next_state_s = DONE;
        end else if (cycle_cnt_r == CW'(DEPTH_MAX)) begin
          next_state_s = DONE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        next_state_s = DONE;
      end
      default: begin
        next_state_s = HOLD;
      end
    endcase
  end

  // State, hold window, run-cycle counter and sticky timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= HOLD;
      hold_cnt_r  <= '0;
      cycle_cnt_r <= '0;
      timeout_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == HOLD) begin
        hold_cnt_r <= hold_cnt_r + HW'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
      if ((state_r == RUN) && (cycle_cnt_r != '1)) begin
        cycle_cnt_r <= cycle_cnt_r + CW'(1);
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (timeout_s) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Directed bench: dut_a (NRET=1, RST_CYC=3) and dut_b (NRET=2, CHANNEL=1, SKIP=4).
module tb_rvfi_check_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic         reset_a, valid_a, core_reset_a, armed_a, check_a, done_a, timeout_a;
  logic [63:0]  order_a, target_a;
  logic [15:0]  retire_a;
  logic [4:0]   cycle_a;

  logic         reset_b, core_reset_b, armed_b, check_b, done_b, timeout_b;
  logic [1:0]   valid_b;
  logic [127:0] order_b;
  logic [63:0]  target_b;
  logic [15:0]  retire_b;
  logic [4:0]   cycle_b;

  rvfi_check_sequencer #(
    .NRET(1), .CHANNEL(0), .RST_CYC(3), .DEPTH_MIN(10), .DEPTH_MAX(20), .SKIP(0)
  ) dut_a (
    .clock(clock), .reset(reset_a), .rvfi_valid(valid_a), .rvfi_order(order_a),
    .target_order(target_a), .core_reset(core_reset_a), .armed(armed_a),
    .check(check_a), .done(done_a), .timeout(timeout_a),
    .retire_count(retire_a), .cycle_count(cycle_a)
  );

  rvfi_check_sequencer #(
    .NRET(2), .CHANNEL(1), .RST_CYC(1), .DEPTH_MIN(10), .DEPTH_MAX(20), .SKIP(4)
  ) dut_b (
    .clock(clock), .reset(reset_b), .rvfi_valid(valid_b), .rvfi_order(order_b),
    .target_order(target_b), .core_reset(core_reset_b), .armed(armed_b),
    .check(check_b), .done(done_b), .timeout(timeout_b),
    .retire_count(retire_b), .cycle_count(cycle_b)
  );

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_reset_a();
    expect_eq("a_rst_core_reset", core_reset_a, 1);
    expect_eq("a_rst_armed", armed_a, 0);
    expect_eq("a_rst_check", check_a, 0);
    expect_eq("a_rst_done", done_a, 0);
    expect_eq("a_rst_timeout", timeout_a, 0);
    expect_eq("a_rst_retire", retire_a, 0);
    expect_eq("a_rst_cycle", cycle_a, 0);
  endtask

  // Three HOLD cycles with target traffic that must be ignored.
  task automatic hold_phase_a();
    for (int i = 0; i < 3; i++) begin
      valid_a = 1'b1;
      order_a = 64'd7;
      #1;
      expect_eq("a_hold_core_reset", core_reset_a, 1);
      expect_eq("a_hold_check", check_a, 0);
      expect_eq("a_hold_retire", retire_a, 0);
      cyc();
    end
  endtask

  task automatic pulse_reset_a();
    reset_a = 1'b1;
    valid_a = 1'b0;
    cyc();
    reset_a = 1'b0;
    #1;
    expect_reset_a();
  endtask

  // One retirement per RUN cycle; order 7 at cycle 5 (too early) and at fire_k.
  task automatic run_a(input int fire_k, input int abort_k);
    int end_k;
    end_k = (fire_k >= 0) ? fire_k : 20;
    for (int k = 0; k <= 20; k++) begin
      valid_a = 1'b1;
      order_a = (k == 5 || k == fire_k) ? 64'd7 : 64'd100 + 64'(k);
      if (k == abort_k) reset_a = 1'b1;
      #1;
      expect_eq("a_run_core_reset", core_reset_a, 0);
      expect_eq("a_run_cycle", cycle_a, 64'(k));
      expect_eq("a_run_retire", retire_a, 64'(k));
      expect_eq("a_run_armed", armed_a, (k >= 10) ? 1 : 0);
      expect_eq("a_run_check", check_a, (k == fire_k) ? 1 : 0);
      expect_eq("a_run_done", done_a, 0);
      cyc();
      if (k == abort_k) begin
        reset_a = 1'b0;
        valid_a = 1'b0;
        #1;
        expect_reset_a();
        return;
      end
      if (k == fire_k) break;
    end
    for (int i = 0; i < 3; i++) begin
      valid_a = 1'b1;
      order_a = 64'd7;
      #1;
      expect_eq("a_done_done", done_a, 1);
      expect_eq("a_done_timeout", timeout_a, (fire_k >= 0) ? 0 : 1);
      expect_eq("a_done_check", check_a, 0);
      expect_eq("a_done_core_reset", core_reset_a, 0);
      expect_eq("a_done_cycle", cycle_a, 64'(end_k + 1));
      expect_eq("a_done_retire", retire_a, 64'(end_k + 1));
      cyc();
    end
  endtask

  task automatic start_b();
    reset_b = 1'b1;
    valid_b = 2'b00;
    cyc();
    reset_b = 1'b0;
    #1;
    expect_eq("b_hold_core_reset", core_reset_b, 1);
    cyc();
  endtask

  initial begin
    reset_a  = 1'b1; valid_a = 1'b0; order_a = '0; target_a = 64'd7;
    reset_b  = 1'b1; valid_b = 2'b00; order_b = '0; target_b = 64'd7;
    cyc();
    cyc();
    reset_a = 1'b0;
    #1;
    expect_reset_a();

    // Fire at cycle 12, then reset in DONE.
    hold_phase_a();
    run_a(12, -1);
    pulse_reset_a();
    // Timeout run.
    hold_phase_a();
    run_a(-1, -1);
    pulse_reset_a();
    // Fire on the last window cycle.
    hold_phase_a();
    run_a(20, -1);
    pulse_reset_a();
    // Abort mid-RUN at cycle 15, then identical rerun.
    hold_phase_a();
    run_a(-1, 15);
    hold_phase_a();
    run_a(12, -1);

    // dut_b: both channels retire each cycle; target on ch0 at 12, ch1 at 13.
    start_b();
    for (int k = 0; k <= 20; k++) begin
      valid_b = 2'b11;
      order_b = {(k == 13) ? 64'd7 : 64'd300 + 64'(k), (k == 12) ? 64'd7 : 64'd200 + 64'(k)};
      #1;
      expect_eq("b_retire", retire_b, 64'(2 * k));
      expect_eq("b_armed", armed_b, (k >= 10) ? 1 : 0);
      expect_eq("b_check", check_b, (k == 13) ? 1 : 0);
      cyc();
      if (k == 13) break;
    end
    #1;
    expect_eq("b_done", done_b, 1);
    expect_eq("b_timeout", timeout_b, 0);
    expect_eq("b_done_retire", retire_b, 28);
    expect_eq("b_done_cycle", cycle_b, 14);

    // dut_b: SKIP not yet met at cycle 10 blocks a ch1 match; met at cycle 12.
    start_b();
    for (int k = 0; k <= 12; k++) begin
      valid_b = (k >= 10) ? 2'b11 : 2'b00;
      order_b = {(k == 10 || k == 12) ? 64'd7 : 64'd300, 64'd200};
      #1;
      expect_eq("b_skip_retire", retire_b, (k <= 10) ? 0 : 64'(2 * (k - 10)));
      expect_eq("b_skip_armed", armed_b, (k == 12) ? 1 : 0);
      expect_eq("b_skip_check", check_b, (k == 12) ? 1 : 0);
      cyc();
    end
    #1;
    expect_eq("b_skip_done", done_b, 1);
    expect_eq("b_skip_final_retire", retire_b, 6);
    expect_eq("b_skip_final_cycle", cycle_b, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
